dot_scan: RTL

Raster scanner that sits directly upstream of the dot-counting stage. On `start` it reads a W×H pixel image from a synchronous-read memory, row by row, and classifies each pixel as a dot or a non-dot. It drives the counter's `enable` once per dot and gives one `rowend` pulse per row. It then signals `done`. The outputs are aligned so that `rowend` never coincides with a valid `enable`.

---
 rtl/dot_scan.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/dot_scan.sv
// ============================================================================
// dot_scan
// ----------------------------------------------------------------------------
// Raster scanner feeding the dot-counting stage. On start it walks a W x H
// image held in a synchronous-read memory, row by row, classifies every pixel
// as dot / non-dot and emits:
//   - one enable pulse per dot pixel,
//   - one rowend pulse after each row (never in the same cycle as an enable),
//   - one done pulse after the final rowend.
//
// Optional feature macro: DOT_SCAN_THRESH_EN
//   defined   : dot = (mem_data >= THRESH), unsigned DW-bit compare
//   undefined : dot = (mem_data != 0), THRESH is ignored
// The FSM and all timing are identical in both builds.
//
// Parameters
//   W      pixels per row (>= 2)
//   H      rows per image (>= 1)
//   DW     pixel data width
//   AW     memory address width, 2**AW >= W*H
//   THRESH dot threshold (threshold build only)
//
// Ports
//   clk      in   single clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   begin a scan, only looked at while idle
//   hold     in   downstream stall, blocks new memory reads
//   mem_rd   out  read strobe to the image memory
//   mem_addr out  read address (row*W + col), holds while mem_rd is low
//   mem_data in   pixel value, valid one cycle after mem_rd
//   enable   out  one pulse per dot pixel
//   rowend   out  one-cycle end-of-row pulse
//   done     out  one-cycle end-of-image pulse
//   busy     out  scan in progress or results still in flight
// ============================================================================
module dot_scan #(
   parameter int W      = 8,
   parameter int H      = 8,
   parameter int DW     = 8,
   parameter int AW     = 6,
   parameter int THRESH = 128
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          hold,
   output logic          mem_rd,
   output logic [AW-1:0] mem_addr,
   input  logic [DW-1:0] mem_data,
   output logic          enable,
   output logic          rowend,
   output logic          done,
   output logic          busy
);

   // Counter widths; a single-row image still needs a 1-bit row counter.
   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam int RW = (H > 1) ? $clog2(H) : 1;

   localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);

   // Elaboration-time sanity check of the parameter set.
   if (W < 2 || H < 1 || DW < 1 || (64'(1) << AW) < 64'(W * H) ||
       THRESH < 0 || 64'(THRESH) >= (64'(1) << DW)) begin : gBadParams
      $error("dot_scan: illegal parameter combination");
   end

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      READ   = 2'd1,
      ROWEND = 2'd2,
      FIN    = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;

   // Reads are issued strictly in raster order, so a running read index is
   // always equal to row*W + col and saves a multiplier.
   logic [AW-1:0] idx_q, idx_d;

   // Last issued address, so mem_addr stays put between reads.
   logic [AW-1:0] addr_q, addr_d;

   // Tags injected into the output pipeline this cycle.
   logic          rdTag;
   logic          reTag;
   logic          dnTag;

   // Stage 1: tags aligned with mem_data coming back from the memory.
   logic          s1Rd_q, s1Re_q, s1Dn_q;

   // Stage 2: the registered outputs.
   logic          enable_q, rowend_q, done_q;

   logic          isDot;

   // ------------------------------------------------------------------------
   // Next-state and tag logic. hold only gates new work (reads and rowend
   // markers); the done marker is always injected once FIN is reached.
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      idx_d   = idx_q;
      rdTag   = 1'b0;
      reTag   = 1'b0;
      dnTag   = 1'b0;

      unique case (state_q)
         IDLE: begin
            col_d = '0;
            row_d = '0;
            idx_d = '0;
            if (start) begin
               state_d = READ;
            end
         end

         READ: begin
            if (!hold) begin
               rdTag = 1'b1;
               idx_d = idx_q + AW'(1);
               if (col_q == COL_LAST) begin
                  col_d   = '0;
                  state_d = ROWEND;
               end else begin
                  col_d = col_q + CW'(1);
               end
            end
         end

         ROWEND: begin
            if (!hold) begin
               reTag = 1'b1;
               if (row_q == ROW_LAST) begin
                  row_d   = '0;
                  state_d = FIN;
               end else begin
                  row_d   = row_q + RW'(1);
                  state_d = READ;
               end
            end
         end

         FIN: begin
            dnTag   = 1'b1;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Address register: capture whatever address goes out with a read.
   // ------------------------------------------------------------------------
   always_comb begin
      addr_d = addr_q;
      if (rdTag) begin
         addr_d = idx_q;
      end
   end

   // ------------------------------------------------------------------------
   // FSM, counters and address register. Reset wins over start and hold.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         col_q   <= '0;
         row_q   <= '0;
         idx_q   <= '0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         row_q   <= row_d;
         idx_q   <= idx_d;
         addr_q  <= addr_d;
      end
   end

   // ------------------------------------------------------------------------
   // Dot classification of the pixel returned by the memory.
   // ------------------------------------------------------------------------
`ifdef DOT_SCAN_THRESH_EN
   assign isDot = (mem_data >= DW'(THRESH));
`else
   assign isDot = (mem_data != '0);
`endif

   // ------------------------------------------------------------------------
   // Two-stage output pipeline. Stage 1 lines the read tag up with mem_data,
   // stage 2 registers the classified result together with the markers. A
   // rowend marker is only injected in a cycle without a read, so rowend and
   // enable can never collide at the output. Reset flushes everything in
   // flight, which is what aborts a scan cleanly.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         s1Rd_q   <= 1'b0;
         s1Re_q   <= 1'b0;
         s1Dn_q   <= 1'b0;
         enable_q <= 1'b0;
         rowend_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         s1Rd_q   <= rdTag;
         s1Re_q   <= reTag;
         s1Dn_q   <= dnTag;
         enable_q <= s1Rd_q & isDot;
         rowend_q <= s1Re_q;
         done_q   <= s1Dn_q;
      end
   end

   assign mem_rd   = rdTag;
   assign mem_addr = rdTag ? idx_q : addr_q;
   assign enable   = enable_q;
   assign rowend   = rowend_q;
   assign done     = done_q;

   // Busy covers the FSM plus every tag still travelling down the pipeline,
   // so it stays high through the cycle that shows done.
   assign busy = (state_q != IDLE) | s1Rd_q | s1Re_q | s1Dn_q |
                 enable_q | rowend_q | done_q;

endmodule
